// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for a shared Montgomery multiplier.
// Works in the Montgomery domain and converts the result back with a final mont(acc, 1).
module montgomery_exp_ctrl #(
  parameter int unsigned WIDTH   = 1024,
  parameter int unsigned E_WIDTH = 1024,
  parameter int unsigned LEN_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x_mont,
  input  logic [WIDTH-1:0]   in_r_mod_m,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]   in_e_len,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               mm_start,
  output logic [WIDTH-1:0]   mm_a,
  output logic [WIDTH-1:0]   mm_b,
  output logic [WIDTH-1:0]   mm_m,
  input  logic [WIDTH-1:0]   mm_result,
  input  logic               mm_done
);

  localparam int unsigned IDX_W = $clog2(E_WIDTH);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_SQ_S, S_SQ_W, S_MUL_S, S_MUL_W, S_POST_S, S_POST_W, S_DONE
  } state_t;

  state_t             state_q;
  logic               busy_q, done_q, mm_start_q;
  logic [WIDTH-1:0]   result_q, mm_a_q, mm_b_q, m_q, x_q, acc_q;
  logic [E_WIDTH-1:0] e_q;
  logic [LEN_W-1:0]   idx_q;
  logic [LEN_W-1:0]   len_d;
  logic               e_bit;

  always_comb begin
    len_d = in_e_len;
    if (in_e_len > LEN_W'(E_WIDTH)) len_d = LEN_W'(E_WIDTH);
  end

  assign e_bit = e_q[idx_q[IDX_W-1:0]];

  // Operand registers are loaded on the edge that enters a *_S state, so they
  // are valid alongside mm_start and stay untouched through the matching wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mm_start_q <= 1'b0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      m_q        <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      e_q        <= '0;
      idx_q      <= '0;
    end else begin
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q     <= in_x_mont;
            m_q     <= in_m;
            e_q     <= in_e;
            acc_q   <= in_r_mod_m;
            idx_q   <= len_d;
            busy_q  <= 1'b1;
            state_q <= S_CHK;
          end
        end
        S_CHK: begin
          mm_a_q     <= acc_q;
          mm_start_q <= 1'b1;
          if (idx_q == '0) begin
            mm_b_q  <= WIDTH'(1);
            state_q <= S_POST_S;
          end else begin
            idx_q   <= idx_q - 1'b1;
            mm_b_q  <= acc_q;
            state_q <= S_SQ_S;
          end
        end
        S_SQ_S: state_q <= S_SQ_W;
        S_SQ_W: begin
          if (mm_done) begin
            acc_q <= mm_result;
            if (e_bit) begin
              mm_a_q     <= mm_result;
              mm_b_q     <= x_q;
              mm_start_q <= 1'b1;
              state_q    <= S_MUL_S;
            end else begin
              state_q <= S_CHK;
            end
          end
        end
        S_MUL_S: state_q <= S_MUL_W;
        S_MUL_W: begin
          if (mm_done) begin
            acc_q   <= mm_result;
            state_q <= S_CHK;
          end
        end
        S_POST_S: state_q <= S_POST_W;
        S_POST_W: begin
          if (mm_done) begin
            result_q <= mm_result;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = m_q;

endmodule

// File: doc/montgomery_exp_ctrl.md
Name: montgomery_exp_ctrl

Overview:
- Sequencer that drives one shared Montgomery multiplier through left-to-right binary exponentiation (square-and-multiply) in the Montgomery domain.
- Computes result = x^e mod m from:
  - x_mont (x·R mod m)
  - r_mod_m (R mod m)
  - the modulus
  - the exponent and its bit length
- Owns the multiplier's start/operand interface, sits between the top-level command logic and the montgomery multiplier instance, and does the final conversion out of the Montgomery domain.

Parameters:
- WIDTH, 1024, operand/modulus width in bits (R = 2^WIDTH).
- E_WIDTH, 1024, exponent register width.
- LEN_W, 11, width of exponent-length field; must hold E_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle command pulse; sampled only in IDLE
- in_x_mont  input  WIDTH  x·R mod m
- in_r_mod_m  input  WIDTH  R mod m (Montgomery one)
- in_m  input  WIDTH  odd modulus
- in_e  input  E_WIDTH  exponent
- in_e_len  input  LEN_W  number of exponent bits t to process (bits t-1..0)
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  x^e mod m, held until next accepted start
- mm_start  output  1  one-cycle pulse to multiplier
- mm_a  output  WIDTH  multiplier operand A
- mm_b  output  WIDTH  multiplier operand B
- mm_m  output  WIDTH  multiplier modulus
- mm_result  input  WIDTH  multiplier output
- mm_done  input  1  multiplier completion pulse

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, mm_start, result, mm_a, mm_b, mm_m, acc, bit index all 0.
- IDLE + start=1:
  - Latch x_mont, m, e, e_len.
  - acc <= in_r_mod_m, idx <= in_e_len.
  - Next state CHK. Inputs need not stay stable after the start cycle.
- States:
  - CHK: if idx==0 → POST_S; else idx <= idx-1 → SQ_S.
  - SQ_S: mm_a=acc, mm_b=acc, mm_start=1 for this cycle only → SQ_W.
  - SQ_W: on mm_done: acc <= mm_result; if e[idx]==1 → MUL_S, else → CHK.
  - MUL_S: mm_a=acc, mm_b=x_mont, mm_start=1 → MUL_W.
  - MUL_W: on mm_done: acc <= mm_result → CHK.
  - POST_S: mm_a=acc, mm_b=1 (WIDTH'b1), mm_start=1 → POST_W.
  - POST_W: on mm_done: result <= mm_result → DONE.
  - DONE: done=1 one cycle, busy=0 → IDLE.
- Operand rules:
  - mm_a, mm_b, mm_m are registered.
  - They are updated in the cycle mm_start is driven and held constant through the matching WAIT.
  - mm_m = latched m for the whole operation.
- mm_done is ignored outside *_W states. It is also ignored in the same cycle as mm_start; WAIT samples it from the cycle after the pulse.
- Multiplier-call count per operation = t + popcount(e[t-1:0]) + 1.
- Latency with multiplier latency L (mm_start to mm_done):
  - Each call costs L+1 cycles plus 1 CHK cycle per exponent bit.
  - done fires 1 cycle after POST_W completes.
- Boundaries:
  - e_len=0 → only the POST call runs; result = mont(R mod m, 1) = 1.
  - e_len > E_WIDTH is clamped to E_WIDTH at latch.
  - start while busy or in DONE is ignored; the latched operands are unchanged.
  - start in the same cycle done is high is ignored; a new start is accepted the next cycle.
  - Exponent bits above e_len-1 are never read.
  - Reset mid-operation aborts immediately; mm_start stays low. A multiplier still running is left to finish, and its mm_done is ignored in IDLE.
- result is not cleared by a new start; it changes only at POST_W completion.

Test Plan:
- Reset, then WIDTH=1024, m=13, x=3, e=5, e_len=3, Montgomery inputs precomputed by the bench, behavioural multiplier with L=10 → exactly 6 mm_start pulses (S,M,S,S,M,P), result=9, one done pulse, busy low after done.
- e=0, e_len=0, same m → exactly 1 mm_start pulse, with mm_b=1 → result=1.
- e=0xFFFF, e_len=16, m=2^1023+1023 (odd), random x → 33 mm calls, result matches the bench's reference modexp; mm_a/mm_b stable across every WAIT window.
- Second start pulsed while busy, and again in the cycle done is high → both ignored; mm_start count and result unchanged; a start the following cycle is accepted.
- Assert reset during MUL_W with L=50 → busy/mm_start drop within the same cycle; the late mm_done from the aborted call causes no transition; the next operation completes correctly.
- Spurious mm_done pulse in IDLE and in the same cycle as mm_start → ignored; the state machine waits for the next mm_done.
